lifo_reverser: RTL and testbench

LIFO_REVERSER -- requirements
Module: lifo_reverser

---
 rtl/lifo_reverser_if.sv | 36 +++
 rtl/lifo_reverser.sv | 122 ++++++++++++
 tb/tb_lifo_reverser.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lifo_reverser_if.sv
// Stream and LIFO handshake bundle for lifo_reverser.
// The reverser sits on the slave modport; the environment (source, sink, LIFO) uses master.
interface lifo_reverser_if #(
  parameter int DATA_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic              lifo_write;
  logic              lifo_read;
  logic [DATA_W-1:0] lifo_datain;
  logic [DATA_W-1:0] lifo_dataout;
  logic              lifo_val;
  logic              lifo_full;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    output lifo_dataout, lifo_val, lifo_full,
    input  in_ready, out_valid, out_data, out_last,
    input  lifo_write, lifo_read, lifo_datain
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    input  lifo_dataout, lifo_val, lifo_full,
    output in_ready, out_valid, out_data, out_last,
    output lifo_write, lifo_read, lifo_datain
  );
endinterface

// File: rtl/lifo_reverser.sv
// Segment reverser: fills an external LIFO with up to LIFO_SIZE words of a segment,
// then pops them back out so each segment leaves in reverse order.
module lifo_reverser #(
  parameter int DATA_W    = 10,
  parameter int LIFO_SIZE = 6
) (
  input  logic             clock,
  input  logic             reset,
  lifo_reverser_if.slave   bus,
  output logic             busy
);

  localparam int CNT_W = $clog2(LIFO_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIFO_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    FILL,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic in_ready;
  logic accept;
  logic pop;
  logic out_fire;
  logic load;

  // Strobes are gated by reset so nothing reaches the LIFO while it is being cleared.
  always_comb begin
    in_ready = reset && (state_q == FILL) && (cnt_q < CNT_MAX) && !bus.lifo_full;
    accept   = bus.in_valid && in_ready;
    out_fire = out_valid_q && bus.out_ready;
    pop      = reset && (state_q == DRAIN) && (cnt_q != '0) && !pend_q &&
               (!out_valid_q || bus.out_ready);
    load     = bus.lifo_val && pend_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (accept) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // The last-flag is decided at pop time and travels with the pending pop.
    if (pop) begin
      pend_d      = 1'b1;
      pend_last_d = (cnt_q == CNT_ONE);
    end else if (load) begin
      pend_d = 1'b0;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.lifo_dataout;
      out_last_d  = pend_last_q;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (accept && (bus.in_last || (cnt_q == CNT_LAST))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.lifo_write  = accept;
  assign bus.lifo_datain = bus.in_data;
  assign bus.lifo_read   = pop;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign busy            = (state_q == DRAIN);

endmodule

// File: tb/tb_lifo_reverser.sv
// Bench for lifo_reverser: a behavioural LIFO, randomized source/sink and a
// segment-reversal reference model built from queues.
module tb_lifo_reverser;

  localparam int DATA_W    = 10;
  localparam int LIFO_SIZE = 6;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } word_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;

  lifo_reverser_if #(.DATA_W(DATA_W)) bus ();

  lifo_reverser #(
    .DATA_W   (DATA_W),
    .LIFO_SIZE(LIFO_SIZE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Attached LIFO: pop data appears one cycle after lifo_read.
  logic [DATA_W-1:0] stack [LIFO_SIZE];
  int depth = 0;
  bit spur  = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth = 0;
      bus.lifo_val     <= 1'b0;
      bus.lifo_dataout <= '0;
    end else begin
      bus.lifo_val <= 1'b0;
      if (bus.lifo_write && depth < LIFO_SIZE) begin
        stack[depth] = bus.lifo_datain;
        depth++;
      end
      if (bus.lifo_read && depth > 0) begin
        depth--;
        bus.lifo_dataout <= stack[depth];
        bus.lifo_val     <= 1'b1;
      end
      if (spur) begin
        bus.lifo_val     <= 1'b1;
        bus.lifo_dataout <= 10'h155;
        spur = 1'b0;
      end
    end
  end

  assign bus.lifo_full = (depth == LIFO_SIZE);

  // Reference model: words to send, current open segment, expected output order.
  word_t src[$];
  word_t seg[$];
  word_t expq[$];
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int    vprob    = 100;
  int    out_cnt  = 0;
  bit                hold_pend = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  always @(negedge clock) begin
    if (!reset) begin
      seg.delete();
      expq.delete();
      hold_pend    = 1'b0;
      bus.in_valid = 1'b0;
    end else begin
      check_eq("busy", busy, expq.size() != 0);
      check_eq("in_ready", bus.in_ready, (expq.size() == 0) && (seg.size() < LIFO_SIZE));
      if (expq.size() == 0) check_eq("out_unexpected", bus.out_valid, 0);
      if (hold_pend) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_data", bus.out_data, hold_data);
        check_eq("hold_last", bus.out_last, hold_last);
      end

      bus.in_valid = (src.size() != 0) && ($urandom_range(99) < vprob);
      if (src.size() != 0) begin
        bus.in_data = src[0].d;
        bus.in_last = src[0].l;
      end else begin
        bus.in_data = DATA_W'($urandom);
        bus.in_last = 1'($urandom);
      end
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(1));

      #1;
      check_eq("wr_rd_excl", bus.lifo_write & bus.lifo_read, 0);
      check_eq("lifo_write", bus.lifo_write, bus.in_valid & bus.in_ready);
      if (bus.lifo_write) begin
        check_eq("lifo_datain", bus.lifo_datain, bus.in_data);
        check_eq("push_when_full", depth < LIFO_SIZE, 1);
      end
      if (bus.lifo_read) check_eq("pop_when_empty", depth > 0, 1);
      if (bus.out_valid && !bus.out_ready) check_eq("read_during_stall", bus.lifo_read, 0);

      hold_pend = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;

      if (bus.in_valid && bus.in_ready) begin
        seg.push_back(src.pop_front());
        if (seg[seg.size()-1].l || seg.size() == LIFO_SIZE) begin
          for (int i = seg.size() - 1; i >= 0; i--) begin
            word_t w;
            w.d = seg[i].d;
            w.l = (i == 0);
            expq.push_back(w);
          end
          seg.delete();
        end
      end

      if (bus.out_valid && bus.out_ready && expq.size() != 0) begin
        word_t e;
        e = expq.pop_front();
        check_eq("out_data", bus.out_data, e.d);
        check_eq("out_last", bus.out_last, e.l);
        out_cnt++;
      end
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    src.push_back(w);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((src.size() + seg.size() + expq.size()) != 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
    check_eq("idle_timeout", src.size() + seg.size() + expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_out_data"}, bus.out_data, 0);
    check_eq({tag, "_out_last"}, bus.out_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_lifo_write"}, bus.lifo_write, 0);
    check_eq({tag, "_lifo_read"}, bus.lifo_read, 0);
  endtask

  initial begin
    int target;
    int k;

    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("reset");

    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_eq("in_ready_after_release", bus.in_ready, 1);

    // Short segment
    push_word(10'h001, 1'b0);
    push_word(10'h002, 1'b0);
    push_word(10'h003, 1'b1);
    wait_idle(100);

    // Single full-scale word
    push_word(10'h3FF, 1'b1);
    wait_idle(50);
    check_eq("fill_after_single", busy, 0);

    // Oversized segment splits at LIFO_SIZE
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i), i == 8);
    wait_idle(200);

    // Downstream stall during drain
    for (int i = 0; i < 4; i++) push_word(DATA_W'(10'h010 + i), i == 3);
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(negedge clock);
      k++;
    end
    check_eq("stall_wait", bus.out_valid, 1);
    rdy_mode = 2;
    repeat (5) @(negedge clock);
    rdy_mode = 0;
    wait_idle(100);

    // Stray lifo_val without a pending pop
    spur = 1'b1;
    repeat (4) @(negedge clock);

    // Reset in the middle of a drain
    target = out_cnt + 2;
    for (int i = 0; i < 4; i++) push_word(DATA_W'(10'h0A0 + i), i == 3);
    k = 0;
    while (out_cnt < target && k < 200) begin
      @(negedge clock);
      k++;
    end
    check_eq("mid_drain_wait", out_cnt >= target, 1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    src.delete();
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_eq("in_ready_after_mid_reset", bus.in_ready, 1);
    push_word(10'h111, 1'b0);
    push_word(10'h222, 1'b0);
    push_word(10'h333, 1'b1);
    wait_idle(100);

    // Random valid/ready stress
    rdy_mode = 1;
    vprob    = 60;
    for (int i = 0; i < 300; i++) begin
      push_word(DATA_W'($urandom), (i == 299) || ($urandom_range(4) == 0));
    end
    wait_idle(6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
